// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder/subtractor.
package seq_addsub_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDigit = 4;
  localparam int unsigned NSTEPS   = DefWidth / DefDigit;

  // Step counter width; never narrower than one bit, even for a single-slice build.
  function automatic int unsigned clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_cpa_slice.sv
// Combinational DIGIT-bit ripple-carry slice; the top time-multiplexes one instance.
module cpa_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic c;

  always_comb begin
    c       = cin_i;
    c_msb_o = cin_i;
    s_o     = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      c_msb_o = c;
      s_o[i]  = a_i[i] ^ b_i[i] ^ c;
      c       = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract, DIGIT bits per cycle, LSB slice first.
// Optional signed saturation of the result: define SEQ_ADDSUB_SAT_EN.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSteps = WIDTH / DIGIT;
  localparam int unsigned StepW  = clog2(NSteps);
  localparam logic [StepW-1:0] LastStep = StepW'(NSteps - 1);

  state_e           state_q;
  logic [StepW-1:0] step_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             cout_q, ovf_q, zero_q;

  int unsigned      base;
  logic [DIGIT-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout, sl_cmsb;
  logic [WIDTH-1:0] res_wrap, res_d;
  logic             ovf_d;

  always_comb begin
    base     = int'(step_q) * DIGIT;
    sl_a     = a_q[base +: DIGIT];
    sl_b     = b_q[base +: DIGIT];
    res_wrap = s_q;
    res_wrap[base +: DIGIT] = sl_s;
    // Only meaningful on the last step, where the slice MSB is the word MSB.
    ovf_d    = sl_cmsb ^ sl_cout;
    res_d    = res_wrap;
`ifdef SEQ_ADDSUB_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    if (ovf_d) begin
      res_d = res_wrap[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  cpa_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .s_o    (sl_s),
    .cout_o (sl_cout),
    .c_msb_o(sl_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub;
            step_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry_q <= sl_cout;
          if (step_q == LastStep) begin
            s_q     <= res_d;
            cout_q  <= sl_cout;
            ovf_q   <= ovf_d;
            zero_q  <= (res_d == '0);
            state_q <= ST_DONE;
          end else begin
            s_q    <= res_wrap;
            step_q <= step_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at DIGIT = 4, 1 and 16 (WIDTH = 16).
module tb_seq_addsub;

  typedef struct {
    string       name;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid[3];
  logic        in_ready[3];
  logic        op_sub[3];
  logic [15:0] a_v[3];
  logic [15:0] b_v[3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [15:0] s_v[3];
  logic        cout_v[3];
  logic        ovf_v[3];
  logic        zero_v[3];

  int   n_cmp;
  int   n_err;
  vec_t vecs[7];
  int   lat_exp[3];

  seq_addsub #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op_sub(op_sub[0]), .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  seq_addsub #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op_sub(op_sub[1]), .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  seq_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .op_sub(op_sub[2]), .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic sub, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] s, input logic c,
                              input logic o, input logic z);
    vec_t v;
    v.name = name; v.sub = sub; v.a = a; v.b = b; v.s = s; v.c = c; v.o = o; v.z = z;
    return v;
  endfunction

  task automatic run_op(input int d, input vec_t v, input int hold);
    int    lat;
    string tag;
    tag = $sformatf("%s/dut%0d", v.name, d);
    @(negedge clk);
    chk({tag, " in_ready before"}, in_ready[d], 1);
    in_valid[d] = 1'b1;
    op_sub[d]   = v.sub;
    a_v[d]      = v.a;
    b_v[d]      = v.b;
    @(posedge clk);
    #1;
    // Scramble inputs after the accepting edge; they must be ignored.
    in_valid[d] = 1'b0;
    op_sub[d]   = ~v.sub;
    a_v[d]      = 16'hDEAD;
    b_v[d]      = 16'hBEEF;
    lat = 1;
    while (!out_valid[d] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, lat_exp[d]);
    chk({tag, " s"}, s_v[d], v.s);
    chk({tag, " cout"}, cout_v[d], v.c);
    chk({tag, " ovf"}, ovf_v[d], v.o);
    chk({tag, " zero"}, zero_v[d], v.z);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold out_valid"}, out_valid[d], 1);
      chk({tag, " hold in_ready"}, in_ready[d], 0);
      chk({tag, " hold s"}, s_v[d], v.s);
      chk({tag, " hold flags"}, {cout_v[d], ovf_v[d], zero_v[d]}, {v.c, v.o, v.z});
    end
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk({tag, " in_ready after release"}, in_ready[d], 1);
    chk({tag, " out_valid after release"}, out_valid[d], 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    lat_exp[0] = 5;
    lat_exp[1] = 17;
    lat_exp[2] = 2;
    vecs[0] = mk("add1234", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk("sub5m3",  1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0);
    vecs[2] = mk("sub3m5",  1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_ADDSUB_SAT_EN
    vecs[3] = mk("addovf",  1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    vecs[4] = mk("subovf",  1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    vecs[3] = mk("addovf",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    vecs[4] = mk("subovf",  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    vecs[5] = mk("subeq",   1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b1);
    vecs[6] = mk("addwrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      op_sub[d]    = 1'b0;
      a_v[d]       = '0;
      b_v[d]       = '0;
      out_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset in_ready/dut%0d", d), in_ready[d], 1);
      chk($sformatf("reset out_valid/dut%0d", d), out_valid[d], 0);
      chk($sformatf("reset s/dut%0d", d), s_v[d], 0);
      chk($sformatf("reset flags/dut%0d", d), {cout_v[d], ovf_v[d], zero_v[d]}, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < ((d == 0) ? 7 : 5); i++) begin
        run_op(d, vecs[i], 0);
      end
    end

    // Back-pressure: result must hold for six stalled cycles.
    run_op(0, vecs[0], 6);

    // Abort mid-RUN at step 2 with a one-cycle reset.
    @(negedge clk);
    in_valid[0] = 1'b1;
    op_sub[0]   = 1'b0;
    a_v[0]      = 16'h1234;
    b_v[0]      = 16'h4321;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid[0], 0);
    chk("abort in_ready", in_ready[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("abort no delivery", out_valid[0], 0);
    end
    run_op(0, mk("after_abort", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
